// File: rtl/calc_pkg.sv
// Shared key codes, ALU/display encodings and FSM states for the keypad calculator.
package calc_pkg;

    localparam logic [3:0] KEY_ADD  = 4'hA;
    localparam logic [3:0] KEY_SUB  = 4'hB;
    localparam logic [3:0] KEY_MUL  = 4'hC;
    localparam logic [3:0] KEY_BKSP = 4'hD;
    localparam logic [3:0] KEY_EQ   = 4'hE;
    localparam logic [3:0] KEY_CLR  = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_MUL = 2'd2;

    localparam logic [1:0] DISP_A   = 2'd0;
    localparam logic [1:0] DISP_B   = 2'd1;
    localparam logic [1:0] DISP_RES = 2'd2;

    typedef enum logic [2:0] {
        ST_ENTRY_A,
        ST_ENTRY_B,
        ST_LAUNCH,
        ST_WAIT,
        ST_SHOW,
        ST_ERR
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_operator(input logic [3:0] k);
        return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        case (k)
            KEY_SUB: return ALU_SUB;
            KEY_MUL: return ALU_MUL;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// One BCD operand: shift-in of digits with saturation at DIGITS, backspace, clear.
// clr together with push restarts the operand with that digit as its first digit.
module bcd_entry_reg #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                push,
    input  logic [3:0]          digit,
    input  logic                pop,
    output logic [4*DIGITS-1:0] o_value
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic [W-1:0]  r_value;
    logic [CW-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || (clr && !push)) begin
            r_value <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_value <= W'(digit);
            r_count <= CW'(1);
        end else if (push && (r_count != CW'(DIGITS))) begin
            r_value <= W'({r_value, digit});
            r_count <= r_count + CW'(1);
        end else if (pop && (r_count != '0)) begin
            r_value <= r_value >> 4;
            r_count <= r_count - CW'(1);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad-driven calculator controller: operand entry, ALU launch/handshake, display select.
// Optional ALU watchdog enabled by defining CALC_ALU_TIMEOUT_EN.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int DIGITS         = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic                alu_done,
    output logic [4*DIGITS-1:0] opnd_a,
    output logic [4*DIGITS-1:0] opnd_b,
    output logic [1:0]          alu_op,
    output logic                alu_start,
    output logic                busy,
    output logic [1:0]          disp_sel,
    output logic                error
);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_alu_op, w_op_nxt;
    logic       w_clr, w_a_push, w_a_pop, w_b_push, w_b_pop;
    logic       w_key_dig, w_key_bksp, w_key_op, w_key_eq, w_key_clr;
    logic       w_timeout;

    assign w_key_dig  = key_valid && is_digit(key_code);
    assign w_key_bksp = key_valid && (key_code == KEY_BKSP);
    assign w_key_op   = key_valid && is_operator(key_code);
    assign w_key_eq   = key_valid && (key_code == KEY_EQ);
    assign w_key_clr  = key_valid && (key_code == KEY_CLR);

`ifdef CALC_ALU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (reset || (r_state != ST_WAIT)) r_wait_cnt <= '0;
        else                               r_wait_cnt <= r_wait_cnt + TW'(1);
    end

    assign w_timeout = (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign error     = (r_state == ST_ERR);
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_alu_op;
        w_clr       = 1'b0;
        w_a_push    = 1'b0;
        w_a_pop     = 1'b0;
        w_b_push    = 1'b0;
        w_b_pop     = 1'b0;
        case (r_state)
            ST_ENTRY_A: begin
                if (w_key_clr) begin
                    w_clr = 1'b1; w_op_nxt = ALU_ADD;
                end else if (w_key_dig) begin
                    w_a_push = 1'b1;
                end else if (w_key_bksp) begin
                    w_a_pop = 1'b1;
                end else if (w_key_op) begin
                    w_op_nxt    = key_to_op(key_code);
                    w_state_nxt = ST_ENTRY_B;
                end
            end
            ST_ENTRY_B: begin
                if (w_key_clr) begin
                    w_clr = 1'b1; w_op_nxt = ALU_ADD; w_state_nxt = ST_ENTRY_A;
                end else if (w_key_dig) begin
                    w_b_push = 1'b1;
                end else if (w_key_bksp) begin
                    w_b_pop = 1'b1;
                end else if (w_key_op) begin
                    w_op_nxt = key_to_op(key_code);
                end else if (w_key_eq) begin
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (w_key_clr) begin
                    w_clr = 1'b1; w_op_nxt = ALU_ADD; w_state_nxt = ST_ENTRY_A;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion in the same cycle as any key takes priority.
                if (alu_done) begin
                    w_state_nxt = ST_SHOW;
                end else if (w_key_clr) begin
                    w_clr = 1'b1; w_op_nxt = ALU_ADD; w_state_nxt = ST_ENTRY_A;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_SHOW: begin
                if (w_key_clr) begin
                    w_clr = 1'b1; w_op_nxt = ALU_ADD; w_state_nxt = ST_ENTRY_A;
                end else if (w_key_dig) begin
                    w_clr = 1'b1; w_a_push = 1'b1; w_state_nxt = ST_ENTRY_A;
                end
            end
            ST_ERR: begin
                if (w_key_clr) begin
                    w_clr = 1'b1; w_op_nxt = ALU_ADD; w_state_nxt = ST_ENTRY_A;
                end
            end
            default: w_state_nxt = ST_ENTRY_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_ENTRY_A;
            r_alu_op <= ALU_ADD;
        end else begin
            r_state  <= w_state_nxt;
            r_alu_op <= w_op_nxt;
        end
    end

    bcd_entry_reg #(.DIGITS(DIGITS)) u_opnd_a (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_clr),
        .push    (w_a_push),
        .digit   (key_code),
        .pop     (w_a_pop),
        .o_value (opnd_a)
    );

    bcd_entry_reg #(.DIGITS(DIGITS)) u_opnd_b (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_clr),
        .push    (w_b_push),
        .digit   (key_code),
        .pop     (w_b_pop),
        .o_value (opnd_b)
    );

    always_comb begin
        case (r_state)
            ST_ENTRY_A: disp_sel = DISP_A;
            ST_SHOW:    disp_sel = DISP_RES;
            default:    disp_sel = DISP_B;
        endcase
    end

    assign alu_op    = r_alu_op;
    assign alu_start = (r_state == ST_LAUNCH);
    assign busy      = (r_state == ST_LAUNCH) || (r_state == ST_WAIT);

endmodule
